// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Merges a non-stallable single-cycle ALU result stream and a load result
// stream into one register-file write port. Loads wait in a 4-entry queue;
// an ALU write to the same register kills older queued loads (WAW).
//
// Build option: define WB_BYPASS_EN to let a load go straight to the write
// port when the ALU is idle and the queue is empty (1-cycle load latency).
// When the macro is not defined, every load is queued (2-cycle latency).

module writeback_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_data,
   output logic [4:0]  rd,
   output logic [31:0] writeData,
   output logic        regWrite,
   output logic [2:0]  fifo_count
);

   logic [4:0]  q_rd   [4];
   logic [31:0] q_data [4];
   logic [3:0]  q_live;
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;

   logic        fifo_empty;
   logic        bypass;
   logic        push;
   logic        pop;
   logic        alu_kill;
   logic        sel_valid;
   logic        sel_we;
   logic [4:0]  sel_rd;
   logic [31:0] sel_data;

   // Ready depends only on the registered occupancy, so a same-cycle pop
   // never opens a slot for a push.
   assign mem_ready  = (fifo_count != 3'd4);
   assign fifo_empty = (fifo_count == 3'd0);

   // An ALU write to a non-zero register supersedes any queued load to it.
   assign alu_kill   = alu_valid && (alu_rd != 5'd0);

`ifdef WB_BYPASS_EN
   // Load goes straight to the write port when nothing else competes.
   assign bypass = !alu_valid && fifo_empty && mem_valid;
`else
   assign bypass = 1'b0;
`endif

   assign push = mem_valid && mem_ready && !bypass;
   assign pop  = !alu_valid && !fifo_empty;

   // Pick this cycle's write source: ALU, then bypassed load, then queue head.
   always_comb begin
      sel_valid = 1'b0;
      sel_we    = 1'b0;
      sel_rd    = 5'd0;
      sel_data  = 32'd0;
      if (alu_valid) begin
         sel_valid = 1'b1;
         sel_we    = (alu_rd != 5'd0);
         sel_rd    = alu_rd;
         sel_data  = alu_data;
      end else if (bypass) begin
         sel_valid = 1'b1;
         sel_we    = (mem_rd != 5'd0);
         sel_rd    = mem_rd;
         sel_data  = mem_data;
      end else if (pop) begin
         sel_valid = 1'b1;
         sel_we    = q_live[rd_ptr] && (q_rd[rd_ptr] != 5'd0);
         sel_rd    = q_rd[rd_ptr];
         sel_data  = q_data[rd_ptr];
      end
   end

   // Load queue storage, pointers, occupancy and WAW kill.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= 2'd0;
         rd_ptr     <= 2'd0;
         fifo_count <= 3'd0;
         q_live     <= 4'd0;
         for (int i = 0; i < 4; i++) begin
            q_rd[i]   <= 5'd0;
            q_data[i] <= 32'd0;
         end
      end else begin
         // Kill first; a same-cycle push below overrides its own slot with
         // a live bit that already accounts for the kill.
         if (alu_kill) begin
            for (int i = 0; i < 4; i++) begin
               if (q_rd[i] == alu_rd) q_live[i] <= 1'b0;
            end
         end
         if (push) begin
            q_rd[wr_ptr]   <= mem_rd;
            q_data[wr_ptr] <= mem_data;
            q_live[wr_ptr] <= !(alu_kill && (mem_rd == alu_rd));
            wr_ptr         <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 3'd1;
            2'b01:   fifo_count <= fifo_count - 3'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Registered write port; address/data hold when nothing is selected.
   always_ff @(posedge clk) begin
      if (rst) begin
         regWrite  <= 1'b0;
         rd        <= 5'd0;
         writeData <= 32'd0;
      end else begin
         regWrite <= sel_we;
         if (sel_valid) begin
            rd        <= sel_rd;
            writeData <= sel_data;
         end
      end
   end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: alu_valid  input  1  single-cycle ALU result present this cycle; cannot be stalled.
REQ-005 Port: alu_rd  input  5  ALU destination register.
REQ-006 Port: alu_data  input  32  ALU result.
REQ-007 Port: mem_valid  input  1  load result offered.
REQ-008 Port: mem_ready  output  1  load result accepted when mem_valid && mem_ready at clk edge.
REQ-009 Port: mem_rd  input  5  load destination register.
REQ-010 Port: mem_data  input  32  load data.
REQ-011 Port: rd  output  5  register file write address, registered.
REQ-012 Port: writeData  output  32  register file write data, registered.
REQ-013 Port: regWrite  output  1  register file write enable, registered.
REQ-014 Port: fifo_count  output  3  load-queue occupancy, 0..4.

Function
REQ-015 SHALL hold a 4-entry FIFO of {rd, data, live} for load results; push on mem_valid && mem_ready.
REQ-016 SHALL drive mem_ready = (fifo_count != 4), from registered count only; no push when full, even if a pop happens that cycle.
REQ-017 Each cycle, the selection is: ALU if alu_valid; else FIFO head if non-empty; else none.
REQ-018 Selected write SHALL appear on rd/writeData/regWrite at the next clk edge. ALU latency is 1 cycle; load latency is at least 2 cycles (push edge, then pop edge).
REQ-019 A FIFO pop SHALL occur only when the FIFO is selected; the head is removed whether live or not.
REQ-020 Popped head with live=0 or rd=0 SHALL produce regWrite=0 that cycle. Ordering is unaffected.
REQ-021 ALU selection with alu_rd=0 SHALL produce regWrite=0.
REQ-022 WAW kill: when alu_valid and alu_rd!=0, every queued entry with rd==alu_rd SHALL be cleared to live=0 at that edge. This includes an entry pushed the same cycle with mem_rd==alu_rd.
REQ-023 When nothing is selected, regWrite SHALL be 0. rd/writeData hold their last values.
REQ-024 Simultaneous push and pop SHALL leave fifo_count unchanged. Pointers are 2-bit and wrap 3->0.
REQ-025 Push into an empty FIFO SHALL NOT be visible to selection in the same cycle (except per REQ-031).

Reset
REQ-026 On rst at a clk edge: regWrite=0, rd=0, writeData=0, fifo_count=0, pointers=0, all live bits=0.
REQ-027 Reset mid-operation SHALL discard all queued loads without issuing writes. A mem handshake in the reset cycle SHALL be ignored.
REQ-028 mem_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-029 Macro WB_BYPASS_EN selects load bypass.
REQ-030 Without WB_BYPASS_EN: REQ-025 holds and the minimum load latency is 2 cycles.
REQ-031 With WB_BYPASS_EN: if alu_valid=0, FIFO empty and mem_valid=1, the load SHALL be written directly at the next edge. It is not pushed, fifo_count stays 0, and load latency is 1 cycle. mem_rd=0 still produces regWrite=0.

Verification
REQ-032 Reset, then alu_valid=1, alu_rd=5, alu_data=0x1234 for one cycle -> next edge regWrite=1, rd=5, writeData=0x1234; following edge regWrite=0.
REQ-033 Push 4 loads (rd 1..4, data 0xA1..0xA4) while alu_valid=1 with rd=9 continuously -> fifo_count=4, mem_ready=0. Drop alu_valid -> writes rd 1,2,3,4 in order on 4 consecutive edges, then mem_ready=1.
REQ-034 Queue load rd=7 data 0xBEEF, then ALU rd=7 data 0x1 -> ALU write of 0x1 to r7. The popped r7 entry produces regWrite=0, and r7 is never written with 0xBEEF.
REQ-035 ALU rd=0 data 0xFFFF and load rd=0 -> regWrite never asserts; fifo_count returns to 0.
REQ-036 Queue 3 loads, assert rst for one cycle -> fifo_count=0, regWrite=0, and no queued write emerges afterward.
REQ-037 Load rd=3 into empty FIFO, ALU idle -> write at 2nd edge without WB_BYPASS_EN, at 1st edge with it. With the macro, fifo_count stays 0.
